collatz_engine: RTL

//  Parametrised Collatz orbit engine: host loads a BITS-wide start value bytewise,

---
 rtl/collatz_pkg.sv | 17 +
 rtl/collatz_step.sv | 41 ++++
 rtl/collatz_engine.sv | 110 +++++++++++
 3 files changed

// File: rtl/collatz_pkg.sv
// Shared types and constants for the Collatz orbit engine.
package collatz_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic REG_LEN = 1'b0;
    localparam logic REG_REC = 1'b1;

    function automatic int lane_count(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/collatz_step.sv
// Combinational Collatz step: next value, odd-step overflow and saturating length increment.
// With COLLATZ_SHORTCUT_EN the halving that always follows an odd step is folded into it.
module collatz_step #(
    parameter int BITS     = 32,
    parameter int LEN_BITS = 16
) (
    input  logic [BITS-1:0]     cur,
    input  logic [LEN_BITS-1:0] len,
    output logic [BITS-1:0]     next_cur,
    output logic [LEN_BITS-1:0] next_len,
    output logic [BITS-1:0]     peak,
    output logic                is_one,
    output logic                ovf
);
    logic [BITS+1:0]   t;
    logic [LEN_BITS:0] len_sum;
    logic [1:0]        inc;

    // 3*cur+1 at BITS+2 width so the overflow bits are visible
    assign t      = {2'b00, cur} + {1'b0, cur, 1'b0} + {{(BITS+1){1'b0}}, 1'b1};
    assign is_one = (cur == {{(BITS-1){1'b0}}, 1'b1});
    assign ovf    = cur[0] && (t[BITS+1:BITS] != 2'b00);
    assign peak   = t[BITS-1:0];

    always_comb begin
        next_cur = cur >> 1;
        inc      = 2'd1;
        if (cur[0]) begin
`ifdef COLLATZ_SHORTCUT_EN
            next_cur = t[BITS:1];
            inc      = 2'd2;
`else
            next_cur = t[BITS-1:0];
`endif
        end
    end

    assign len_sum  = {1'b0, len} + (LEN_BITS+1)'(inc);
    assign next_len = len_sum[LEN_BITS] ? {LEN_BITS{1'b1}} : len_sum[LEN_BITS-1:0];

endmodule

// File: rtl/collatz_engine.sv
// Collatz orbit engine: bytewise start-value load, start/busy/done handshake, length/record readback.
// Build option COLLATZ_SHORTCUT_EN selects the merged odd+halve step inside collatz_step.
module collatz_engine
    import collatz_pkg::*;
#(
    parameter int BITS      = 32,
    parameter int LEN_BITS  = 16,
    parameter int ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);
    // state | meaning
    // IDLE  | out of reset, waiting for start
    // RUN   | iterating the orbit, one step per cycle
    // DONE  | result held, waiting for the next start
    localparam int LANE_W    = ADDR_BITS - 1;
    localparam int RD_W      = 8 * (2 ** LANE_W);
    localparam int NUM_LANES = lane_count(BITS);

    state_t              state, state_next;
    logic [BITS-1:0]     num, cur, record, next_cur, peak;
    logic [LEN_BITS-1:0] len, next_len;
    logic                is_one, step_ovf, accept;
    logic [LANE_W-1:0]   lane;
    logic [RD_W-1:0]     rd_field;

    collatz_step #(.BITS(BITS), .LEN_BITS(LEN_BITS)) u_step (
        .cur      (cur),
        .len      (len),
        .next_cur (next_cur),
        .next_len (next_len),
        .peak     (peak),
        .is_one   (is_one),
        .ovf      (step_ovf)
    );

    assign accept = start && (state != RUN);
    assign lane   = addr[LANE_W-1:0];
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = (num == '0) ? DONE : RUN;
            RUN:        if (is_one || step_ovf) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // Zero start is an immediate overflow result rather than an endless orbit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur      <= '0;
            len      <= '0;
            record   <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            cur      <= num;
            len      <= '0;
            record   <= num;
            overflow <= (num == '0);
        end else if (state == RUN && !is_one) begin
            if (step_ovf) begin
                overflow <= 1'b1;
            end else begin
                cur <= next_cur;
                len <= next_len;
                if (cur[0] && peak > record) record <= peak;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num <= '0;
        end else if (wr_en && state != RUN) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (int'(lane) == i) num[8*i +: 8] <= wdata;
            end
        end
    end

    always_comb begin
        rd_field = '0;
        if (addr[ADDR_BITS-1] == REG_REC) rd_field[BITS-1:0]     = record;
        else                              rd_field[LEN_BITS-1:0] = len;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      rdata <= 8'h00;
        else if (rd_en) rdata <= rd_field[{lane, 3'b000} +: 8];
    end

endmodule
